stream_rr_arbiter: RTL and testbench

Parametrised N-channel round-robin merger that collects 32-bit words from per-module readout FIFOs (SPI RX, TDC, TLU, …) into the single stream feeding `sram_fifo`. It generalises the two-channel merge with these additions:

- configurable channel count and data width
- a bounded burst length per grant
- a runtime channel enable mask
- optional in-band channel tagging
- a registered output stage with a proper downstream back-pressure handshake

---
 rtl/stream_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_stream_rr_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// N-channel round-robin merger: FWFT readout FIFOs in, one registered stream out.
// Bounded bursts, enable mask, hold requests, optional channel tag in the top data bits.
module stream_rr_arbiter #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int TAG_ENABLE = 0,
  localparam int ID_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           BUS_CLK,
  input  logic                           BUS_RST,
  input  logic [CHANNELS-1:0]            WRITE_REQ,
  input  logic [CHANNELS-1:0]            HOLD_REQ,
  input  logic [CHANNELS*DATA_WIDTH-1:0] DATA_IN,
  input  logic [CHANNELS-1:0]            ENABLE_MASK,
  output logic [CHANNELS-1:0]            READ_GRANT,
  input  logic                           READY_OUT,
  output logic                           WRITE_OUT,
  output logic [DATA_WIDTH-1:0]          DATA_OUT,
  output logic [ID_BITS-1:0]             CHANNEL_OUT
);

  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [ID_BITS-1:0] LAST_INIT = ID_BITS'(CHANNELS - 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]            state;
  logic [ID_BITS-1:0]    cur;
  logic [ID_BITS-1:0]    last;
  logic [BW-1:0]         burst_cnt;
  logic [BW-1:0]         burst_next;
  logic [DATA_WIDTH-1:0] words [CHANNELS];
  logic [DATA_WIDTH-1:0] out_word;
  logic [ID_BITS-1:0]    hit_idx;
  logic                  hit_found;
  logic                  slot_free;
  logic                  limit;
  logic                  strobe;
  logic                  leave;
  logic                  cur_req;
  logic                  cur_en;
  logic                  cur_hold;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      words[i] = DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Rotating priority search starting one past the previously served channel.
  always_comb begin
    int idx;
    idx       = 0;
    hit_found = 1'b0;
    hit_idx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(last) + 1 + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!hit_found && WRITE_REQ[idx] && ENABLE_MASK[idx]) begin
        hit_found = 1'b1;
        hit_idx   = ID_BITS'(idx);
      end
    end
  end

  always_comb begin
    cur_req   = WRITE_REQ[cur];
    cur_en    = ENABLE_MASK[cur];
    cur_hold  = HOLD_REQ[cur];
    slot_free = !WRITE_OUT || READY_OUT;
    limit     = (MAX_BURST != 0) && !cur_hold && (burst_cnt == BURST_MAX);
    strobe    = (state == GRANT) && !BUS_RST && cur_req && cur_en && slot_free && !limit;
    burst_next = burst_cnt;
    if (strobe && (MAX_BURST != 0) && (burst_cnt != BURST_MAX)) begin
      burst_next = burst_cnt + 1'b1;
    end
    // A disabled channel is dropped even if it asks to hold.
    leave = !cur_en ||
            (!cur_hold && (!cur_req || ((MAX_BURST != 0) && (burst_next == BURST_MAX))));
  end

  always_comb begin
    READ_GRANT = '0;
    if (strobe) READ_GRANT[cur] = 1'b1;
  end

  always_comb begin
    out_word = words[cur];
    if (TAG_ENABLE != 0) out_word[DATA_WIDTH-1 -: ID_BITS] = cur;
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state     <= IDLE;
      cur       <= '0;
      last      <= LAST_INIT;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit_found) begin
            cur       <= hit_idx;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          burst_cnt <= burst_next;
          if (leave) begin
            state <= IDLE;
            last  <= cur;
          end
        end
      endcase
    end
  end

  // Output register only advances when its slot is free, so stalls never drop words.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      WRITE_OUT   <= 1'b0;
      DATA_OUT    <= '0;
      CHANNEL_OUT <= '0;
    end else if (strobe) begin
      WRITE_OUT   <= 1'b1;
      DATA_OUT    <= out_word;
      CHANNEL_OUT <= cur;
    end else if (READY_OUT) begin
      WRITE_OUT   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: instance 0 is MAX_BURST=16 untagged,
// instance 1 is MAX_BURST=2 tagged; FWFT FIFOs are modelled per channel.
module tb_stream_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [3:0]   write_req;
  logic [3:0]   hold_req;
  logic [3:0]   enable_mask;
  logic [127:0] data_in;
  logic         ready_out;

  logic [3:0]  grant_v [2];
  logic        wo_v    [2];
  logic [31:0] dout_v  [2];
  logic [1:0]  ch_v    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    stream_rr_arbiter #(
      .CHANNELS(4), .DATA_WIDTH(32),
      .MAX_BURST(g == 0 ? 16 : 2), .TAG_ENABLE(g == 0 ? 0 : 1)
    ) dut (
      .BUS_CLK(clk), .BUS_RST(rst),
      .WRITE_REQ(write_req), .HOLD_REQ(hold_req), .DATA_IN(data_in),
      .ENABLE_MASK(enable_mask), .READ_GRANT(grant_v[g]), .READY_OUT(ready_out),
      .WRITE_OUT(wo_v[g]), .DATA_OUT(dout_v[g]), .CHANNEL_OUT(ch_v[g])
    );
  end

  int          sel = 0;
  logic [3:0]  grant;
  logic        wo;
  logic [31:0] dout;
  logic [1:0]  ch;

  always_comb begin
    grant = grant_v[sel];
    wo    = wo_v[sel];
    dout  = dout_v[sel];
    ch    = ch_v[sel];
  end

  logic [31:0] mem [4][8];
  int          cnt [4];
  int          rp  [4];
  logic [33:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;
  int          n_strobes = 0;

  function automatic logic [31:0] word(input int c, input int k);
    return 32'hA500_0000 | (32'(c) << 8) | 32'(k);
  endfunction

  function automatic logic [33:0] expect_of(input int c, input logic [31:0] w);
    if (sel == 1) return {2'(c), 2'(c), w[29:0]};
    return {2'(c), w};
  endfunction

  task automatic checkOutput(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic update_inputs();
    for (int i = 0; i < 4; i++) begin
      if (rp[i] < cnt[i]) begin
        write_req[i]        = 1'b1;
        data_in[i*32 +: 32] = mem[i][rp[i]];
      end else begin
        write_req[i]        = 1'b0;
        data_in[i*32 +: 32] = 32'h0;
      end
    end
  endtask

  task automatic load(input int c, input int n);
    for (int k = 0; k < n; k++) mem[c][cnt[c] + k] = word(c, cnt[c] + k);
    cnt[c] += n;
  endtask

  task automatic push_exp(input int c, input int k);
    exp_q.push_back(expect_of(c, word(c, k)));
  endtask

  // One clock: grant sampled mid-cycle pops the FIFO model at the edge.
  task automatic applyStimulus();
    logic [3:0] g;
    @(negedge clk);
    g = grant;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) begin
        rp[i]++;
        n_strobes++;
      end
    end
    update_inputs();
    #1;
  endtask

  task automatic begin_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      rp[i]  = 0;
    end
    hold_req    = 4'b0000;
    enable_mask = 4'b1111;
    ready_out   = 1'b1;
    exp_q.delete();
    update_inputs();
    applyStimulus();
    applyStimulus();
    n_strobes = 0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 80 && exp_q.size() > 0; i++) applyStimulus();
    checkOutput(name, 34'(exp_q.size()), 34'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && wo && ready_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got %0h expected none", {ch, dout});
      end else begin
        checkOutput("out_word", {ch, dout}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic seen;

    $display("[TB] round-robin");
    sel = 0;
    begin_reset();
    checkOutput("rst_write_out", 34'(wo), 34'd0);
    checkOutput("rst_data_out", 34'(dout), 34'd0);
    checkOutput("rst_channel_out", 34'(ch), 34'd0);
    checkOutput("rst_read_grant", 34'(grant), 34'd0);
    for (int c = 0; c < 4; c++) load(c, 3);
    for (int c = 0; c < 4; c++) for (int k = 0; k < 3; k++) push_exp(c, k);
    update_inputs();
    rst = 1'b0;
    applyStimulus();
    checkOutput("first_grant_ch0", 34'({wo, grant}), 34'b00001);
    applyStimulus();
    checkOutput("write_out_cycle2", 34'(wo), 34'd1);
    drain("rr_drained");

    $display("[TB] burst limit");
    sel = 1;
    begin_reset();
    load(0, 5);
    load(1, 5);
    push_exp(0, 0); push_exp(0, 1); push_exp(1, 0); push_exp(1, 1);
    push_exp(0, 2); push_exp(0, 3); push_exp(1, 2); push_exp(1, 3);
    push_exp(0, 4); push_exp(1, 4);
    update_inputs();
    rst = 1'b0;
    drain("burst_drained");
    checkOutput("burst_strobes", 34'(n_strobes), 34'd10);

    $display("[TB] hold");
    sel = 0;
    begin_reset();
    load(1, 2);
    load(2, 2);
    hold_req = 4'b0010;
    push_exp(1, 0); push_exp(1, 1); push_exp(2, 0); push_exp(2, 1);
    update_inputs();
    rst = 1'b0;
    repeat (3) applyStimulus();
    for (int i = 0; i < 4; i++) begin
      checkOutput("hold_no_grant", 34'(grant), 34'd0);
      applyStimulus();
    end
    hold_req = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      applyStimulus();
      seen = grant[2];
    end
    checkOutput("hold_release_ch2", 34'(seen), 34'd1);
    drain("hold_drained");

    $display("[TB] back-pressure");
    sel = 0;
    begin_reset();
    load(0, 4);
    for (int k = 0; k < 4; k++) push_exp(0, k);
    update_inputs();
    rst = 1'b0;
    repeat (3) applyStimulus();
    ready_out = 1'b0;
    #1;
    checkOutput("bp_no_strobe", 34'(grant), 34'd0);
    applyStimulus();
    checkOutput("bp_hold_data_1", 34'({wo, dout}), 34'({1'b1, word(0, 1)}));
    applyStimulus();
    checkOutput("bp_hold_data_2", 34'({wo, dout}), 34'({1'b1, word(0, 1)}));
    ready_out = 1'b1;
    drain("bp_drained");
    checkOutput("bp_strobes", 34'(n_strobes), 34'd4);

    $display("[TB] tag and mask");
    sel = 1;
    begin_reset();
    mem[2][0] = 32'hFFFF_FFFF;
    cnt[2]    = 1;
    exp_q.push_back({2'd2, 32'hBFFF_FFFF});
    update_inputs();
    rst = 1'b0;
    repeat (2) applyStimulus();
    checkOutput("tag_word", {ch, dout}, {2'd2, 32'hBFFF_FFFF});
    drain("tag_drained");
    begin_reset();
    enable_mask = 4'b1011;
    load(2, 2);
    load(3, 1);
    push_exp(3, 0);
    update_inputs();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus();
      if (grant[2]) seen = 1'b1;
    end
    checkOutput("mask_never_granted", 34'(seen), 34'd0);
    checkOutput("mask_ch2_untouched", 34'(rp[2]), 34'd0);
    checkOutput("mask_ch3_drained", 34'(exp_q.size()), 34'd0);

    $display("[TB] reset mid-burst");
    sel = 0;
    begin_reset();
    load(1, 4);
    update_inputs();
    rst = 1'b0;
    applyStimulus();
    checkOutput("mid_grant_ch1", 34'(grant), 34'b0010);
    applyStimulus();
    rst = 1'b1;
    #1;
    checkOutput("rst_cycle_no_strobe", 34'(grant), 34'd0);
    applyStimulus();
    load(0, 2);
    push_exp(0, 0); push_exp(0, 1);
    push_exp(1, 1); push_exp(1, 2); push_exp(1, 3);
    update_inputs();
    rst = 1'b0;
    #1;
    checkOutput("post_rst_write_out", 34'(wo), 34'd0);
    checkOutput("post_rst_grant", 34'(grant), 34'd0);
    applyStimulus();
    checkOutput("post_rst_ch0_first", 34'(grant), 34'b0001);
    drain("post_rst_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
